// File: rtl/alu_datapath.sv
// alu_datapath: multi-cycle 8-bit ADD/SUB/MUL/DIV execution unit behind an enable/done handshake.
// Define ALU_DATAPATH_DIV_EN to build the restoring divider; otherwise opcode 3 behaves as a no-op.
module alu_datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       opcode,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DIV,
    S_DONE,
    S_HOLD
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;

  state_t      state_reg;
  logic [3:0]  op_reg;
  logic [7:0]  a_reg;
  logic [7:0]  b_reg;
  logic [2:0]  cnt_reg;
  logic        run_reg;
  logic [15:0] acc_reg;
  logic [15:0] mcand_reg;
  logic [7:0]  mplier_reg;
  logic [15:0] result_reg;
  logic        carry_reg;
  logic        div_zero_reg;
  logic        busy_reg;
  logic        done_reg;

  logic [8:0]  add_sum;
  logic [7:0]  sub_diff;
  logic [15:0] mul_next;

  always_comb begin
    add_sum  = {1'b0, a_reg} + {1'b0, b_reg};
    sub_diff = a_reg - b_reg;
    mul_next = acc_reg + (mplier_reg[0] ? mcand_reg : 16'd0);
  end

`ifdef ALU_DATAPATH_DIV_EN
  logic [7:0] rem_reg;
  logic [7:0] quo_reg;
  logic [8:0] rem_shift;
  logic       rem_ge;
  logic [7:0] rem_next;
  logic [7:0] quo_next;

  // Remainder stays below the divisor, so the 8-bit subtraction never loses information.
  always_comb begin
    rem_shift = {rem_reg, quo_reg[7]};
    rem_ge    = (rem_shift >= {1'b0, b_reg});
    rem_next  = rem_ge ? (rem_shift[7:0] - b_reg) : rem_shift[7:0];
    quo_next  = {quo_reg[6:0], rem_ge};
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      op_reg       <= 4'd0;
      a_reg        <= 8'd0;
      b_reg        <= 8'd0;
      cnt_reg      <= 3'd0;
      run_reg      <= 1'b0;
      acc_reg      <= 16'd0;
      mcand_reg    <= 16'd0;
      mplier_reg   <= 8'd0;
      result_reg   <= 16'd0;
      carry_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef ALU_DATAPATH_DIV_EN
      rem_reg      <= 8'd0;
      quo_reg      <= 8'd0;
`endif
    end else begin
      // Status outputs lag the state by one cycle so done coincides with the final busy cycle.
      done_reg <= (state_reg == S_DONE);
      busy_reg <= (state_reg == S_EXEC) || (state_reg == S_MUL) ||
                  (state_reg == S_DIV)  || (state_reg == S_DONE);

      case (state_reg)
        S_IDLE: begin
          if (enable) begin
            op_reg       <= opcode;
            a_reg        <= a;
            b_reg        <= b;
            carry_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            cnt_reg      <= 3'd0;
            run_reg      <= 1'b0;
            case (opcode)
              OP_MUL:  state_reg <= S_MUL;
`ifdef ALU_DATAPATH_DIV_EN
              OP_DIV:  state_reg <= S_DIV;
`endif
              default: state_reg <= S_EXEC;
            endcase
          end
        end

        S_EXEC: begin
          case (op_reg)
            OP_ADD: begin
              result_reg <= {7'd0, add_sum};
              carry_reg  <= add_sum[8];
            end
            OP_SUB: begin
              result_reg <= {8'd0, sub_diff};
              carry_reg  <= (a_reg < b_reg);
            end
            default: ;
          endcase
          state_reg <= S_DONE;
        end

        // First cycle loads the shift registers, then eight shift-add steps follow.
        S_MUL: begin
          if (!run_reg) begin
            acc_reg    <= 16'd0;
            mcand_reg  <= {8'd0, a_reg};
            mplier_reg <= b_reg;
            cnt_reg    <= 3'd0;
            run_reg    <= 1'b1;
          end else begin
            acc_reg    <= mul_next;
            mcand_reg  <= {mcand_reg[14:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[7:1]};
            cnt_reg    <= cnt_reg + 3'd1;
            if (cnt_reg == 3'd7) begin
              result_reg <= mul_next;
              run_reg    <= 1'b0;
              state_reg  <= S_DONE;
            end
          end
        end

`ifdef ALU_DATAPATH_DIV_EN
        S_DIV: begin
          if (!run_reg) begin
            if (b_reg == 8'd0) begin
              result_reg   <= {a_reg, 8'hFF};
              div_zero_reg <= 1'b1;
              state_reg    <= S_DONE;
            end else begin
              rem_reg <= 8'd0;
              quo_reg <= a_reg;
              cnt_reg <= 3'd0;
              run_reg <= 1'b1;
            end
          end else begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            cnt_reg <= cnt_reg + 3'd1;
            if (cnt_reg == 3'd7) begin
              result_reg <= {rem_next, quo_next};
              run_reg    <= 1'b0;
              state_reg  <= S_DONE;
            end
          end
        end
`endif

        S_DONE: begin
          cnt_reg   <= 3'd0;
          state_reg <= enable ? S_HOLD : S_IDLE;
        end

        // Controller still asserting enable for the finished op; wait for it to let go.
        S_HOLD: begin
          if (!enable) begin
            state_reg <= S_IDLE;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  generate
    if (WIDTH > 16) begin : g_wide
      assign result = {{(WIDTH - 16){1'b0}}, result_reg};
    end else begin : g_narrow
      assign result = result_reg;
    end
  endgenerate

  assign carry    = carry_reg;
  assign div_zero = div_zero_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_alu_datapath.sv
// Scoreboard bench for alu_datapath: stimulus queues expected responses, a monitor checks each done pulse.
module tb_alu_datapath;

  localparam int WIDTH = 20;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [3:0]       opcode;
  logic [7:0]       a;
  logic [7:0]       b;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             div_zero;
  logic             busy;
  logic             done;

  alu_datapath #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .opcode   (opcode),
    .a        (a),
    .b        (b),
    .result   (result),
    .carry    (carry),
    .div_zero (div_zero),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        dz;
    int          cap;
    int          lat;
    int          bsy;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  // Monitor: pops one expectation per done pulse, also polices pulse width and stray dones.
  initial begin
    int   busy_run;
    logic prev_done;
    exp_t e;
    busy_run  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) busy_run++;
      else busy_run = 0;
      if (prev_done) begin
        checks++;
        if (done) begin
          errors++;
          $display("FAIL done_width cycle=%0d done stayed high for a second cycle", cycle);
        end
      end
      if (done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done cycle=%0d no operation outstanding", cycle);
        end else begin
          e = q.pop_front();
          checks++;
          if (result !== WIDTH'(e.res)) begin
            errors++;
            $display("FAIL %s result got=%h want=%h", e.name, result, WIDTH'(e.res));
          end
          checks++;
          if (carry !== e.c) begin
            errors++;
            $display("FAIL %s carry got=%b want=%b", e.name, carry, e.c);
          end
          checks++;
          if (div_zero !== e.dz) begin
            errors++;
            $display("FAIL %s div_zero got=%b want=%b", e.name, div_zero, e.dz);
          end
          checks++;
          if (cycle - e.cap != e.lat) begin
            errors++;
            $display("FAIL %s latency got=%0d want=%0d", e.name, cycle - e.cap, e.lat);
          end
          checks++;
          if (busy_run != e.bsy) begin
            errors++;
            $display("FAIL %s busy_cycles got=%0d want=%0d", e.name, busy_run, e.bsy);
          end
          $display("op %-8s result=%h carry=%b div_zero=%b latency=%0d busy=%0d",
                   e.name, result, carry, div_zero, cycle - e.cap, busy_run);
        end
      end
      prev_done = done;
    end
  end

  task automatic check_val(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Issues one op, scrambles the inputs after capture, waits for done, then releases enable.
  task automatic run_op(input string name, input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] res, input logic c, input logic dz,
                        input int lat, input int hold);
    exp_t e;
    bit   seen;
    @(negedge clk);
    enable = 1'b1;
    opcode = op;
    a      = av;
    b      = bv;
    e.res  = res;
    e.c    = c;
    e.dz   = dz;
    e.cap  = cycle + 1;
    e.lat  = lat;
    e.bsy  = lat;
    e.name = name;
    q.push_back(e);
    @(posedge clk);
    #1;
    opcode = ~op;
    a      = ~av;
    b      = bv ^ 8'h5A;
    seen   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for done", name);
      if (q.size() != 0) void'(q.pop_back());
    end
    repeat (hold) @(negedge clk);
    enable = 1'b0;
  endtask

  initial begin
    logic [15:0] div_res;
    logic [15:0] dz_res;
    logic        dz_flag;
    int          div_lat;

    reset  = 1'b1;
    enable = 1'b0;
    opcode = 4'd0;
    a      = 8'd0;
    b      = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_val("reset_result", result, '0);
    check_val("reset_carry", WIDTH'(carry), '0);
    check_val("reset_div_zero", WIDTH'(div_zero), '0);
    check_val("reset_busy", WIDTH'(busy), '0);
    check_val("reset_done", WIDTH'(done), '0);

    run_op("add",     4'd0, 8'hF0, 8'h20, 16'h0110, 1'b1, 1'b0, 2, 0);
    run_op("sub_neg", 4'd1, 8'h05, 8'h07, 16'h00FE, 1'b1, 1'b0, 2, 0);
    run_op("mul_ff",  4'd2, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 10, 0);
    run_op("sub_pos", 4'd1, 8'h07, 8'h05, 16'h0002, 1'b0, 1'b0, 2, 0);

`ifdef ALU_DATAPATH_DIV_EN
    div_res = 16'h041C;
    div_lat = 10;
    dz_res  = 16'h33FF;
    dz_flag = 1'b1;
`else
    div_res = 16'h0002;
    div_lat = 2;
    dz_res  = 16'h0002;
    dz_flag = 1'b0;
`endif
    run_op("div",     4'd3, 8'd200, 8'd7, div_res, 1'b0, 1'b0, div_lat, 0);
    run_op("div_zero", 4'd3, 8'h33, 8'h00, dz_res, 1'b0, dz_flag, 2, 0);

    run_op("add_cy",  4'd0, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0, 2, 0);
    run_op("nop",     4'd7, 8'h01, 8'h01, 16'h0100, 1'b0, 1'b0, 2, 0);

    run_op("hold",    4'd0, 8'h12, 8'h34, 16'h0046, 1'b0, 1'b0, 2, 5);
    run_op("rearm",   4'd0, 8'h10, 8'h20, 16'h0030, 1'b0, 1'b0, 2, 0);
    run_op("mul_small", 4'd2, 8'h0D, 8'h0B, 16'h008F, 1'b0, 1'b0, 10, 0);

    // Reset lands on the fourth edge after a MUL capture; no done may follow.
    @(negedge clk);
    enable = 1'b1;
    opcode = 4'd2;
    a      = 8'hFF;
    b      = 8'hFF;
    repeat (4) @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check_val("abort_result", result, '0);
    check_val("abort_carry", WIDTH'(carry), '0);
    check_val("abort_div_zero", WIDTH'(div_zero), '0);
    check_val("abort_busy", WIDTH'(busy), '0);
    check_val("abort_done", WIDTH'(done), '0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    $display("op abort    reset applied mid-MUL, outputs cleared");

    run_op("add_1_1", 4'd0, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b0, 2, 0);

    repeat (4) @(negedge clk);
    check_val("queue_drained", WIDTH'(q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_datapath.md
# alu_datapath

Execution unit on the far side of the controller's `enable`/`opcode`/`a`/`b`/`done` interface. Captures a decoded instruction when `enable` is high, executes ADD, SUB, MUL or DIV on 8-bit operands over one or more cycles, and returns a registered result with a one-cycle `done` pulse. The controller holds `enable` high until it samples `done`.

## Interface
- `WIDTH`, 16, result width; values must be ≥16, and upper bits above 15 are zero.
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: execute request, level, held by controller until `done`.
- `opcode` input 4: 0 ADD, 1 SUB, 2 MUL, 3 DIV, others no-op.
- `a` input 8: operand A / dividend.
- `b` input 8: operand B / divisor.
- `result` output WIDTH: registered result.
- `carry` output 1: ADD carry-out or SUB borrow; 0 for other ops.
- `div_zero` output 1: DIV with `b`==0.
- `busy` output 1: high in CAPTURE-to-DONE states, inclusive.
- `done` output 1: single-cycle completion pulse.

## Operation
- States: IDLE, EXEC, MUL, DIV, DONE, HOLD.
- IDLE: if `enable`, latch `opcode`/`a`/`b` at the edge and go to EXEC (ops 0, 1, and no-ops), MUL (op 2), or DIV (op 3).
- EXEC: ADD: `result` = zero-extended 9-bit a+b, `carry` = bit 8. SUB: `result` = zero-extended (a−b) mod 256, `carry` = (a<b). No-op: `result` is unchanged and `carry` = 0. Next state is DONE.
- MUL: shift-add, one multiplier bit per cycle, 8 iterations via a 3-bit counter. The 16-bit unsigned product goes to `result[15:0]`. Next state is DONE.
- DIV: restoring division, one quotient bit per cycle, 8 iterations. `result[7:0]` = quotient, `result[15:8]` = remainder.
  - If `b`==0 on entry, skip the iterations. Set `result` = {a, 8'hFF} and `div_zero` = 1. Next state is DONE.
- DONE: `done`=1 for exactly this cycle. If `enable` is low, go to IDLE; otherwise go to HOLD.
- HOLD: wait for `enable`==0, then go to IDLE. This prevents re-execution of the same instruction.
- `result`, `carry` and `div_zero` keep their values until the next op writes them. `div_zero` and `carry` clear on every new capture.
- Operand or opcode changes on the inputs after capture have no effect.

## Timing
- Reset: state IDLE. `result`=0, `carry`=0, `div_zero`=0, `busy`=0, `done`=0. Iteration counter is 0.
- Reset mid-operation aborts the op in the next cycle. No `done` is issued.
- Latency counts from the capture edge (edge 0) to the cycle in which `done`=1:
  - ADD, SUB, no-op: `done` high after edge 2.
  - MUL, and DIV with `b`≠0: `done` high after edge 10.
  - DIV with `b`==0: `done` high after edge 2.
- `result` is valid in the same cycle as `done` and remains valid afterwards.
- Back-to-back: `enable` low for at least one cycle is needed between ops. The earliest next capture is the edge after `enable` is sampled low in DONE or HOLD.
- `enable` dropping mid-operation is ignored. The op completes and `done` still pulses.

## Configuration
- `ALU_DATAPATH_DIV_EN` defined: the DIV state and the restoring divider are built as described.
- `ALU_DATAPATH_DIV_EN` undefined: opcode 3 is handled as a no-op.
  - Path is EXEC then DONE; `done` is high after edge 2.
  - `result` is unchanged; `div_zero` = 0.
  - No divider logic is instantiated.

## Test plan
- ADD: a=8'hF0, b=8'h20 → `result`=16'h0110, `carry`=1, `done` high after edge 2.
- SUB: a=8'h05, b=8'h07 → `result`=16'h00FE, `carry`=1. Then a=8'h07, b=8'h05 → `result`=16'h0002, `carry`=0.
- MUL: a=8'hFF, b=8'hFF → `result`=16'hFE01 after edge 10. `busy` is high for 10 cycles and `done` is exactly one cycle wide.
- DIV (macro defined): a=8'd200, b=8'd7 → `result`=16'h041C (remainder 4, quotient 28). Then b=0, a=8'h33 → `result`=16'h33FF, `div_zero`=1, `done` high after edge 2. With the macro undefined: `result` is unchanged and `div_zero`=0.
- Handshake: hold `enable` high for 5 cycles after `done` → no second `done`. Drop `enable` for 1 cycle, then raise it with opcode 0 → a new op is captured and `done` pulses again.
- Reset at cycle 4 of a MUL → all outputs 0 on the next cycle, no `done`. A following ADD 1+1 returns 16'h0002.
